// File: rtl/chunked_serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_defs
//   Shared definitions for the chunked serial adder/subtractor:
//     - state_e : controller states (IDLE, RUN)
//     - mode_e  : arithmetic mode (ADD, SUB)
//     - idx_width(n) : width of the chunk index register for n chunks,
//                      never narrower than one bit so that a single-chunk
//                      configuration still has a legal index register.
// ----------------------------------------------------------------------------
package adder_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Bits needed to count 0 .. n-1, minimum one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// ----------------------------------------------------------------------------
// chunk_adder
//   Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//
// Ports
//   x  [CHUNK] : addend
//   y  [CHUNK] : addend (already inverted by the caller in subtract mode)
//   ci         : carry into bit 0
//   s  [CHUNK] : sum bits
//   co         : carry out of bit CHUNK-1
// ----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  // Internal carry chain: c_s[i] is the carry into bit i.
  logic [CHUNK:0] c_s;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (x[i] & c_s[i]) | (y[i] & c_s[i]);
    end
    co = c_s[CHUNK];
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// ----------------------------------------------------------------------------
// chunked_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operation is processed CHUNK
//   bits per clock, least-significant chunk first, with the inter-chunk
//   carry held in a register. One operation takes N = WIDTH/CHUNK cycles.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   start : operation request, only honoured while idle
//   sub   : 0 = a + b + cin, 1 = a - b (cin ignored)
//   cin   : carry-in for add mode
//   a, b  : operands, captured on the accepting edge
//   busy  : high while an operation is in progress
//   done  : one-cycle pulse, result valid
//   sum   : result, held until the next accepted start
//   cout  : carry out of the MSB (subtract: 1 = no borrow)
//   ovf   : signed two's-complement overflow
// ----------------------------------------------------------------------------
module chunked_serial_adder
  import adder_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);

  // Registered state
  state_e           state_q;
  mode_e            mode_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  // Datapath for the current chunk
  logic [CHUNK-1:0] x_s;
  logic [CHUNK-1:0] y_s;
  logic [CHUNK-1:0] s_s;
  logic             co_s;
  logic             last_s;
  logic             b_msb_s;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  // Operand B is held as captured; the subtract-mode inversion is applied to
  // each chunk on its way into the adder, so B' = B ^ {WIDTH{sub}} overall.
  always_comb begin
    x_s     = a_q[idx_q*CHUNK +: CHUNK];
    y_s     = b_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{mode_q == MODE_SUB}};
    b_msb_s = b_q[WIDTH-1] ^ (mode_q == MODE_SUB);
    last_s  = (idx_q == IW'(N - 1));
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .x (x_s),
    .y (y_s),
    .ci(carry_q),
    .s (s_s),
    .co(co_s)
  );

  // Next result word and overflow flag. On the last chunk s_s carries the
  // result MSB, so overflow is judged from the chunk output directly.
  always_comb begin
    sum_d                       = sum_q;
    sum_d[idx_q*CHUNK +: CHUNK] = s_s;
    ovf_d = (a_q[WIDTH-1] == b_msb_s) && (s_s[CHUNK-1] != a_q[WIDTH-1]);
  end

  // Controller FSM with operand, carry, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ADD;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless the last chunk re-asserts it.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= sub ? MODE_SUB : MODE_ADD;
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= co_s;
          if (last_s) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cout_q  <= co_s;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
